// File: rtl/etc_frame_pkg.sv
// Shared types and constants for the ETC speed-frame packer.
package etc_frame_pkg;

  typedef enum logic [2:0] {IDLE, HDR, SEQ, SPH, SPL, CHK} state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 5;

endpackage

// File: rtl/etc_frame_packer.sv
// Packs ETC speed measurements into 5-byte frames (HEADER, SEQ, SPD_H, SPD_L, CHK)
// for a transmit FIFO, with a one-deep pending buffer and a saturating drop counter.
module etc_frame_packer
  import etc_frame_pkg::*;
#(
  parameter int         WIDTH_SPEED = 14,
  parameter int         DATA_SIZE   = 8,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   full,
  output logic                   write,
  output logic [DATA_SIZE-1:0]   data,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  if (DATA_SIZE != 8 || WIDTH_SPEED < 1 || WIDTH_SPEED > 16) begin : g_bad_param
    $error("etc_frame_packer: DATA_SIZE must be 8 and WIDTH_SPEED in 1..16");
  end

  function automatic logic [7:0] chk_byte(input logic [7:0] seq_b,
                                          input logic [7:0] hi_b,
                                          input logic [7:0] lo_b);
    return seq_b ^ hi_b ^ lo_b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  state_e      state_q;
  logic        pend_vld_q;
  logic [7:0]  seq_q;
  logic [7:0]  drop_q;
  logic [15:0] act_q;
  logic [15:0] pend_q;
  logic [15:0] spd_ext;
  logic [7:0]  byte_sel;
  logic        active;

  assign spd_ext  = 16'(speed);
  assign active   = (state_q != IDLE);
  assign write    = active && !full && !reset;
  assign busy     = active || pend_vld_q;
  assign drop_cnt = drop_q;

  always_comb begin
    byte_sel = 8'd0;
    case (state_q)
      HDR:     byte_sel = HEADER;
      SEQ:     byte_sel = seq_q;
      SPH:     byte_sel = act_q[15:8];
      SPL:     byte_sel = act_q[7:0];
      CHK:     byte_sel = chk_byte(seq_q, act_q[15:8], act_q[7:0]);
      default: byte_sel = 8'd0;
    endcase
  end

  assign data = reset ? '0 : DATA_SIZE'(byte_sel);

  // Control: FSM, pending flag, frame counter, drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      seq_q      <= 8'd0;
      drop_q     <= 8'd0;
    end else begin
      if (done && active) begin
        if (!pend_vld_q) pend_vld_q <= 1'b1;
        else             drop_q     <= sat_inc(drop_q);
      end
      case (state_q)
        IDLE: if (done)  state_q <= HDR;
        HDR:  if (write) state_q <= SEQ;
        SEQ:  if (write) state_q <= SPH;
        SPH:  if (write) state_q <= SPL;
        SPL:  if (write) state_q <= CHK;
        CHK: begin
          if (write) begin
            seq_q <= seq_q + 8'd1;
            // A done arriving now is either dropped (pending full) or starts the next frame directly.
            if (pend_vld_q || done) begin
              state_q    <= HDR;
              pend_vld_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data: active and pending speed words.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && done) begin
      act_q <= spd_ext;
    end else if (state_q == CHK && write) begin
      if (pend_vld_q)  act_q <= pend_q;
      else if (done)   act_q <= spd_ext;
    end
    if (done && active && !pend_vld_q) pend_q <= spd_ext;
  end

endmodule

// File: tb/tb_etc_frame_packer.sv
// Directed bench for etc_frame_packer: frame content, timing, back-pressure,
// overflow, mid-frame reset and sequence wrap.
module tb_etc_frame_packer;
  import etc_frame_pkg::*;

  logic        clk;
  logic        reset;
  logic        done;
  logic [13:0] speed;
  logic        full;
  logic        write;
  logic [7:0]  data;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_c = 0;
  int done_c = 0;

  logic [7:0] wq[$];
  int         wc[$];

  etc_frame_packer dut (
    .clk      (clk),
    .reset    (reset),
    .done     (done),
    .speed    (speed),
    .full     (full),
    .write    (write),
    .data     (data),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wq.push_back(data);
      wc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [39:0] exp,
                              input bit consec, input int first_exp);
    int c;
    int prev;
    logic [7:0] b;
    prev = 0;
    check({tag, "_len"}, 32'(wq.size() >= FRAME_LEN), 32'd1);
    if (wq.size() >= FRAME_LEN) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        b = wq.pop_front();
        c = wc.pop_front();
        check($sformatf("%s_b%0d", tag, k), {24'd0, b}, {24'd0, exp[39-8*k -: 8]});
        if (k == 0 && first_exp >= 0) check($sformatf("%s_t0", tag), c, first_exp);
        if (k > 0 && consec) check($sformatf("%s_t%0d", tag, k), c, prev + 1);
        prev = c;
      end
      last_c = prev;
    end
  endtask

  initial begin
    reset = 1'b1;
    done  = 1'b0;
    speed = '0;
    full  = 1'b0;
    tick();
    tick();
    #1;
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    reset = 1'b0;
    tick();

    // First frame, timing from done
    speed = 14'h1234; done = 1'b1; done_c = cyc;
    tick();
    done = 1'b0;
    check("A_busy", {31'd0, busy}, 32'd1);
    run_idle("A");
    expect_frame("A", 40'hA5_00_12_34_26, 1'b1, done_c + 1);

    speed = 14'h0001; done = 1'b1; done_c = cyc;
    tick();
    done = 1'b0;
    run_idle("B");
    expect_frame("B", 40'hA5_01_00_01_00, 1'b1, done_c + 1);

    // Back-pressure after SPD_H
    speed = 14'h0BCD; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      full = 1'b1;
      #1;
      check($sformatf("full_write%0d", i), {31'd0, write}, 32'd0);
      check($sformatf("full_data%0d", i), {24'd0, data}, 32'h0000_00CD);
      tick();
    end
    full = 1'b0;
    run_idle("F");
    expect_frame("F", 40'hA5_02_0B_CD_C4, 1'b0, -1);

    // Three measurements inside one frame
    speed = 14'h0100; done = 1'b1;
    tick();
    speed = 14'h0200;
    tick();
    speed = 14'h0300;
    tick();
    done = 1'b0;
    check("ovf_drop", {24'd0, drop_cnt}, 32'd1);
    run_idle("O");
    expect_frame("O1", 40'hA5_03_01_00_02, 1'b1, -1);
    expect_frame("O2", 40'hA5_04_02_00_06, 1'b1, last_c + 1);
    check("ovf_empty", wq.size(), 32'd0);

    // done during the CHK write with pending empty
    speed = 14'h0005; done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    speed = 14'h0006; done = 1'b1;
    tick();
    done = 1'b0;
    #1;
    check("c26_hdr", {24'd0, data}, 32'h0000_00A5);
    run_idle("C");
    expect_frame("C1", 40'hA5_05_00_05_00, 1'b1, -1);
    expect_frame("C2", 40'hA5_06_00_06_00, 1'b1, last_c + 1);
    check("c26_drop", {24'd0, drop_cnt}, 32'd1);

    // Reset after the SEQ byte, with done held during reset
    speed = 14'h1111; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    reset = 1'b1; done = 1'b1; speed = 14'h2222;
    #1;
    check("mr_write_in_rst", {31'd0, write}, 32'd0);
    tick();
    reset = 1'b0; done = 1'b0;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_write", {31'd0, write}, 32'd0);
    check("mr_data", {24'd0, data}, 32'd0);
    check("mr_drop", {24'd0, drop_cnt}, 32'd0);
    tick();
    tick();
    check("mr_busy_later", {31'd0, busy}, 32'd0);
    check("mr_len", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      check("mr_b0", {24'd0, wq[0]}, 32'h0000_00A5);
      check("mr_b1", {24'd0, wq[1]}, 32'h0000_0007);
    end
    wq.delete();
    wc.delete();

    speed = 14'h0042; done = 1'b1;
    tick();
    done = 1'b0;
    run_idle("R");
    expect_frame("R", 40'hA5_00_00_42_42, 1'b1, -1);

    // Frames 2..257 after reset: sequence wrap
    for (int i = 1; i <= 256; i++) begin
      speed = 14'(i); done = 1'b1;
      tick();
      done = 1'b0;
      run_idle("W");
      if (i == 255)      expect_frame("seqFF", 40'hA5_FF_00_FF_00, 1'b1, -1);
      else if (i == 256) expect_frame("seq00", 40'hA5_00_01_00_01, 1'b1, -1);
      else begin
        wq.delete();
        wc.delete();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
